// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the raw pins, deframes 11-bit frames and folds
// E0/F0 prefixes into single-cycle key events for the keyboard matrix block.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 48000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic       key_extended,
    output logic [7:0] key_code,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_s, dat_s;
    logic          clk_sync, dat_sync;
    logic          filt_clk;
    logic [FW-1:0] fcnt;
    logic          fall;

    state_t        state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par;
    logic          ext, brk;
    logic [TW-1:0] tcnt;

    assign clk_sync = clk_s[1];
    assign dat_sync = dat_s[1];
    // The filter output drops on the FILTER_LEN-th consecutive low sample; that cycle is the fall.
    assign fall = filt_clk & ~clk_sync & (fcnt == FW'(FILTER_LEN - 1));

    function automatic logic is_discard(input logic [7:0] b);
        case (b)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_discard = 1'b1;
            default:                                  is_discard = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_s    <= 2'b11;
            dat_s    <= 2'b11;
            filt_clk <= 1'b1;
            fcnt     <= '0;
        end else begin
            clk_s <= {clk_s[0], ps2_clk};
            dat_s <= {dat_s[0], ps2_data};
            if (clk_sync != filt_clk) begin
                if (fcnt == FW'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_sync;
                    fcnt     <= '0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= IDLE;
            bitcnt       <= '0;
            shreg        <= '0;
            par          <= 1'b0;
            ext          <= 1'b0;
            brk          <= 1'b0;
            tcnt         <= '0;
            key_strobe   <= 1'b0;
            key_pressed  <= 1'b0;
            key_extended <= 1'b0;
            key_code     <= '0;
            frame_err    <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            frame_err  <= 1'b0;
            if (state == IDLE) begin
                tcnt <= '0;
                if (fall && !dat_sync) begin
                    state  <= DATA;
                    bitcnt <= '0;
                end
            end else if (fall) begin
                tcnt <= '0;
                case (state)
                    DATA: begin
                        shreg  <= {dat_sync, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= dat_sync;
                        state <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        // Good frame: stop high and odd parity over data plus parity bit.
                        if (!(dat_sync && (^{shreg, par}))) begin
                            frame_err <= 1'b1;
                            ext       <= 1'b0;
                            brk       <= 1'b0;
                        end else if (shreg == 8'hE0) begin
                            ext <= 1'b1;
                        end else if (shreg == 8'hF0) begin
                            brk <= 1'b1;
                        end else if (is_discard(shreg)) begin
                            ext <= 1'b0;
                            brk <= 1'b0;
                        end else begin
                            key_strobe   <= 1'b1;
                            key_code     <= shreg;
                            key_pressed  <= ~brk;
                            key_extended <= ext;
                            ext          <= 1'b0;
                            brk          <= 1'b0;
                        end
                    end
                endcase
            end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                ext       <= 1'b0;
                brk       <= 1'b0;
                tcnt      <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized PS/2 frame stimulus against an event-queue model of the prefix/discard rules.
module tb_ps2_key_decoder;
    localparam int FL = 8;
    localparam int TO = 400;
    localparam int H  = 30;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_strobe, key_pressed, key_extended, frame_err;
    logic [7:0] key_code;

    ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_strobe(key_strobe), .key_pressed(key_pressed), .key_extended(key_extended),
        .key_code(key_code), .frame_err(frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        bit         err;
        logic [7:0] code;
        bit         pressed;
        bit         ext;
    } ev_t;

    ev_t exp_q[$];
    bit  m_ext, m_brk;
    int  n_cmp = 0, n_bad = 0;
    int  cyc = 0, err_cyc = 0, fall_cyc = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every output event must match the head of the expected-event queue.
    always @(negedge clk_sys) begin
        if (!reset && (key_strobe || frame_err)) begin
            if (key_strobe && frame_err) chk("strobe_and_err", 1, 0);
            if (frame_err) err_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {30'd0, key_strobe, frame_err}, 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("event_kind_err", frame_err, e.err);
                if (key_strobe) begin
                    chk("key_code", key_code, e.code);
                    chk("key_pressed", key_pressed, e.pressed);
                    chk("key_extended", key_extended, e.ext);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Reference: what a good/bad received byte means at the key-event level.
    task automatic model_byte(input logic [7:0] b, input bit good);
        ev_t e;
        if (!good) begin
            e = '{err: 1, code: 8'h00, pressed: 0, ext: 0};
            exp_q.push_back(e);
            m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
            m_ext = 0; m_brk = 0;
        end else begin
            e = '{err: 0, code: b, pressed: !m_brk, ext: m_ext};
            exp_q.push_back(e);
            m_ext = 0; m_brk = 0;
        end
    endtask

    // Device drives data while clk is high, then pulls clk low; optional short low glitch.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (i == glitch_at) begin
                wait_cyc(5);
                ps2_clk = 0;
                wait_cyc(FL - 2);
                ps2_clk = 1;
                wait_cyc(H - 5 - (FL - 2));
            end else begin
                wait_cyc(H);
            end
            ps2_clk = 0;
            fall_cyc = cyc;
            wait_cyc(H);
            ps2_clk = 1;
        end
        wait_cyc(H);
        ps2_data = 1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int glitch_at);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        model_byte(b, !bad_par && !bad_stop);
        send_bits(bits, 11, glitch_at);
        wait_cyc(20);
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1;
        wait_cyc(3);
        chk("rst_strobe", key_strobe, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_code", key_code, 0);
        chk("rst_pressed", key_pressed, 0);
        chk("rst_ext", key_extended, 0);
        ps2_clk = 1; ps2_data = 1;
        m_ext = 0; m_brk = 0;
        wait_cyc(2);
        reset = 0;
        wait_cyc(20);
    endtask

    initial begin
        int gap;
        logic [7:0] b;
        int r;
        m_ext = 0; m_brk = 0;
        wait_cyc(2);
        do_reset();

        send_frame(8'h1C, 0, 0, -1);
        send_frame(8'hE0, 0, 0, -1);
        send_frame(8'hF0, 0, 0, -1);
        send_frame(8'h75, 0, 0, -1);
        send_frame(8'hF0, 0, 0, -1);
        send_frame(8'hE0, 0, 0, -1);
        send_frame(8'h6B, 0, 0, -1);
        send_frame(8'h1C, 1, 0, -1);
        send_frame(8'h1C, 0, 0, -1);
        send_frame(8'h22, 0, 1, -1);

        // Timeout: start + 5 data bits, clock left high.
        model_byte(8'h00, 0);
        send_bits(11'b000_0010_1100, 6, -1);
        wait_cyc(TO + 60);
        gap = err_cyc - fall_cyc;
        chk("timeout_gap_in_window", (gap >= TO && gap <= TO + FL + 8) ? 1 : 0, 1);
        chk("timeout_drain", exp_q.size(), 0);
        send_frame(8'h29, 0, 0, -1);

        // Reset between prefix and code, and in the middle of a frame.
        send_frame(8'hE0, 0, 0, -1);
        do_reset();
        send_frame(8'h75, 0, 0, -1);
        send_frame(8'hF0, 0, 0, -1);
        send_bits(11'b000_0011_0100, 4, -1);
        do_reset();
        send_frame(8'h75, 0, 0, -1);
        send_frame(8'hE0, 0, 0, -1);
        send_frame(8'hFA, 0, 0, -1);
        send_frame(8'hAA, 0, 0, -1);
        send_frame(8'h16, 0, 0, -1);

        // Filtered glitches: idle, and mid data.
        ps2_clk = 0; wait_cyc(FL - 2); ps2_clk = 1; wait_cyc(20);
        chk("idle_glitch_drain", exp_q.size(), 0);
        send_frame(8'h5A, 0, 0, 4);

        for (int i = 0; i < 36; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: begin
                    logic [7:0] d[6];
                    d = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
                    b = d[$urandom_range(0, 5)];
                end
                default: b = 8'($urandom);
            endcase
            send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0,
                       ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
